pb_debounce_repeat: RTL
=======================

# pb_debounce_repeat

Push-button conditioning stage that sits directly upstream of the counter-control logic. It synchronises the active-low board push buttons and debounces them with hysteresis on a shared 1 kHz sample tick. For each button it emits a clean level plus one-clock press, release and auto-repeat pulses, so downstream control logic consumes single-cycle events instead of doing its own edge detection.

## Interface
Parameters:
- NUM_BUTTONS, 4, number of button channels
- SAMPLE_DIV, 50000, CLOCK_50_I cycles per sample tick (1 ms at 50 MHz)
- DEBOUNCE_DEPTH, 10, consecutive equal samples required to change level
- HOLD_TICKS, 500, sample ticks held before first repeat
- REPEAT_TICKS, 100, sample ticks between subsequent repeats

Ports:
- CLOCK_50_I  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- PUSH_BUTTON_N_I  in  NUM_BUTTONS  raw buttons, active-low, asynchronous to clock
- repeat_en_i  in  NUM_BUTTONS  per-channel auto-repeat enable
- pb_level_o  out  NUM_BUTTONS  debounced level, 1 = pressed
- pb_press_o  out  NUM_BUTTONS  one-cycle pulse on debounced press
- pb_release_o  out  NUM_BUTTONS  one-cycle pulse on debounced release
- pb_repeat_o  out  NUM_BUTTONS  one-cycle pulse per auto-repeat event
- sample_tick_o  out  1  one-cycle pulse each sample tick (shared with neighbours)

## Operation
- Input path: invert PUSH_BUTTON_N_I, then 2-flop synchroniser per bit.
- Tick divider:
  - counts 0..SAMPLE_DIV-1 and wraps.
  - Tick is asserted for one cycle when count == SAMPLE_DIV-1.
- Per channel, on tick:
  - Shift the synchronised bit into a DEBOUNCE_DEPTH-bit shift register.
  - Level sets when the register is all ones.
  - Level clears when the register is all zeros.
  - Otherwise the level holds (hysteresis).
- Per-channel FSM, states PB_IDLE / PB_HELD / PB_REPEAT, with a tick counter of width $clog2(max(HOLD_TICKS,REPEAT_TICKS)+1):
  - PB_IDLE → PB_HELD on level rise. Pulse press, clear counter.
  - PB_HELD: counter increments on each tick and saturates at HOLD_TICKS. When it reaches HOLD_TICKS with repeat_en_i high → PB_REPEAT, pulse repeat, clear counter.
  - PB_REPEAT: counter increments on each tick. On reaching REPEAT_TICKS, pulse repeat and clear counter.
  - PB_REPEAT with repeat_en_i low → PB_HELD with counter held at HOLD_TICKS. No pulse is emitted; if repeat_en_i later returns high, the next tick resumes repeating.
  - Any state → PB_IDLE on level fall. Pulse release, clear counter. Release takes priority over a repeat due in the same cycle.
- Channels are independent. Simultaneous events on different channels all pulse in the same cycle.

## Timing
- Reset values:
  - all outputs 0
  - synchronisers, shift registers, levels and counters 0
  - FSMs PB_IDLE
  - divider 0
- Outputs are all registered.
- pb_level_o changes one cycle after the tick whose shift makes the register uniform.
- pb_press_o / pb_release_o assert in the same cycle as the pb_level_o change, for exactly one cycle.
- pb_repeat_o lands one cycle after the qualifying tick, for one cycle.
- Press latency, from a stable input change to the level change:
  - minimum 2 sync cycles + (DEBOUNCE_DEPTH−1)·SAMPLE_DIV + 2 cycles
  - maximum adds SAMPLE_DIV.
- Glitches shorter than DEBOUNCE_DEPTH ticks never change the level.
- Reset asserted mid-operation clears everything immediately. No pulses are emitted on reset exit.

## Structure
- Package pb_debounce_pkg: typedef enum logic [1:0] pb_state_t {PB_IDLE, PB_HELD, PB_REPEAT}.
- Sub-module pb_channel holds one channel's synchroniser, shift register, level, FSM and pulse registers. It is instantiated NUM_BUTTONS times via generate.
- The tick divider lives in the top module and is shared by all channels.

## Test plan
Bench parameters for all scenarios: SAMPLE_DIV=4, DEBOUNCE_DEPTH=3, HOLD_TICKS=5, REPEAT_TICKS=2, NUM_BUTTONS=4.
- Reset: assert resetn=0 mid-hold on ch0 → all outputs 0 and FSM PB_IDLE immediately; after release of reset, no pulses until a new press completes 3 ticks.
- Clean press: drive PUSH_BUTTON_N_I[0]=0 steady → pb_level_o[0]=1 within 2+8+2..2+12+2 cycles; pb_press_o[0] high exactly one cycle; release yields one pb_release_o[0] pulse.
- Bounce: toggle ch1 every 5 cycles for 60 cycles, then hold low → exactly one press pulse, no release pulse, level rises only after 3 stable ticks.
- Auto-repeat: hold ch2 with repeat_en_i[2]=1 → first repeat 5 ticks after press, then a repeat every 2 ticks; with repeat_en_i[2]=0 → no repeat pulses.
- Simultaneous: press ch0 and ch3 on the same cycle → press pulses in the same cycle. Releasing ch2 on its repeat-due tick → release pulse only, no repeat pulse.

Source files
------------

// File: rtl/pb_debounce_pkg.sv
// Shared types for the push-button conditioning stage.
//   pb_state_t : per-channel hold/auto-repeat state.
//   max_u      : helper for sizing the per-channel tick counter.
package pb_debounce_pkg;

  typedef enum logic [1:0] {
    PB_IDLE   = 2'd0,
    PB_HELD   = 2'd1,
    PB_REPEAT = 2'd2
  } pb_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pb_channel.sv
// One push-button channel: 2-flop synchroniser, hysteresis debouncer and
// press/release/auto-repeat event generator.
//   CLOCK_50_I   : system clock
//   resetn       : asynchronous active-low reset
//   i_btn_n      : raw button, active-low, asynchronous
//   i_tick       : shared one-cycle sample tick
//   i_repeat_en  : auto-repeat enable
//   o_level      : debounced level (1 = pressed)
//   o_press      : one-cycle pulse on debounced press
//   o_release    : one-cycle pulse on debounced release
//   o_repeat     : one-cycle pulse per auto-repeat event
// DEBOUNCE_DEPTH must be at least 2.
module pb_channel
  import pb_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_DEPTH = 10,
  parameter int unsigned HOLD_TICKS     = 500,
  parameter int unsigned REPEAT_TICKS   = 100,
  parameter int unsigned CNT_W          = 9
) (
  input  logic CLOCK_50_I,
  input  logic resetn,
  input  logic i_btn_n,
  input  logic i_tick,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPEAT_TICKS);

  logic                      r_sync1, r_sync2;
  logic [DEBOUNCE_DEPTH-1:0] r_shift, w_shift_next;
  logic                      r_level, w_level_next;
  pb_state_t                 r_state, w_state_next;
  logic [CNT_W-1:0]          r_cnt, w_cnt_next, w_cnt_inc;
  logic                      r_press, r_release, r_repeat;
  logic                      w_press, w_release, w_repeat;
  logic                      w_fall_due;

  always_comb begin
    w_shift_next = r_shift;
    if (i_tick) w_shift_next = {r_shift[DEBOUNCE_DEPTH-2:0], r_sync2};

    w_level_next = r_level;
    if (&r_shift)       w_level_next = 1'b1;
    else if (~|r_shift) w_level_next = 1'b0;

    // The tick that empties the shift register lands one cycle before the
    // level falls; a repeat due on that tick is dropped so the release wins.
    w_fall_due = r_level & i_tick & ~(|w_shift_next);
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cnt_inc    = r_cnt + CNT_W'(1);
    w_press      = 1'b0;
    w_release    = 1'b0;
    w_repeat     = 1'b0;

    if (r_level && !w_level_next) begin
      w_state_next = PB_IDLE;
      w_release    = 1'b1;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        PB_IDLE: begin
          if (w_level_next && !r_level) begin
            w_state_next = PB_HELD;
            w_press      = 1'b1;
            w_cnt_next   = '0;
          end
        end
        PB_HELD: begin
          if (i_tick && !w_fall_due) begin
            // Saturated count plus a re-enabled repeat resumes on this tick.
            if (r_cnt == HOLD_C || w_cnt_inc == HOLD_C) begin
              if (i_repeat_en) begin
                w_state_next = PB_REPEAT;
                w_repeat     = 1'b1;
                w_cnt_next   = '0;
              end else begin
                w_cnt_next   = HOLD_C;
              end
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end
        end
        PB_REPEAT: begin
          if (!i_repeat_en) begin
            w_state_next = PB_HELD;
            w_cnt_next   = HOLD_C;
          end else if (i_tick && !w_fall_due) begin
            if (w_cnt_inc == REP_C) begin
              w_repeat   = 1'b1;
              w_cnt_next = '0;
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end
        end
        default: begin
          w_state_next = PB_IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_shift   <= '0;
      r_level   <= 1'b0;
      r_state   <= PB_IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_sync1   <= ~i_btn_n;
      r_sync2   <= r_sync1;
      r_shift   <= w_shift_next;
      r_level   <= w_level_next;
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_press   <= w_press;
      r_release <= w_release;
      r_repeat  <= w_repeat;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/pb_debounce_repeat.sv
// Push-button conditioning: shared sample-tick divider plus NUM_BUTTONS
// debounce/auto-repeat channels.
//   CLOCK_50_I      : system clock
//   resetn          : asynchronous active-low reset
//   PUSH_BUTTON_N_I : raw buttons, active-low, asynchronous
//   repeat_en_i     : per-channel auto-repeat enable
//   pb_level_o      : debounced levels (1 = pressed)
//   pb_press_o      : one-cycle press pulses
//   pb_release_o    : one-cycle release pulses
//   pb_repeat_o     : one-cycle auto-repeat pulses
//   sample_tick_o   : one-cycle pulse per sample tick
module pb_debounce_repeat
  import pb_debounce_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS    = 4,
  parameter int unsigned SAMPLE_DIV     = 50000,
  parameter int unsigned DEBOUNCE_DEPTH = 10,
  parameter int unsigned HOLD_TICKS     = 500,
  parameter int unsigned REPEAT_TICKS   = 100
) (
  input  logic                   CLOCK_50_I,
  input  logic                   resetn,
  input  logic [NUM_BUTTONS-1:0] PUSH_BUTTON_N_I,
  input  logic [NUM_BUTTONS-1:0] repeat_en_i,
  output logic [NUM_BUTTONS-1:0] pb_level_o,
  output logic [NUM_BUTTONS-1:0] pb_press_o,
  output logic [NUM_BUTTONS-1:0] pb_release_o,
  output logic [NUM_BUTTONS-1:0] pb_repeat_o,
  output logic                   sample_tick_o
);

  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(max_u(HOLD_TICKS, REPEAT_TICKS) + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0] r_div, w_div_next;
  logic             r_tick;

  always_comb begin
    w_div_next = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
  end

  // Tick is registered from the next count so it is high exactly while
  // the divider holds its last value.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= w_div_next;
      r_tick <= (w_div_next == DIV_LAST);
    end
  end

  assign sample_tick_o = r_tick;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
    pb_channel #(
      .DEBOUNCE_DEPTH (DEBOUNCE_DEPTH),
      .HOLD_TICKS     (HOLD_TICKS),
      .REPEAT_TICKS   (REPEAT_TICKS),
      .CNT_W          (CNT_W)
    ) u_ch (
      .CLOCK_50_I  (CLOCK_50_I),
      .resetn      (resetn),
      .i_btn_n     (PUSH_BUTTON_N_I[g]),
      .i_tick      (r_tick),
      .i_repeat_en (repeat_en_i[g]),
      .o_level     (pb_level_o[g]),
      .o_press     (pb_press_o[g]),
      .o_release   (pb_release_o[g]),
      .o_repeat    (pb_repeat_o[g])
    );
  end

endmodule
